// File: rtl/load_use_scoreboard.sv
// load_use_scoreboard: per-GPR load-latency down-counters that raise the ID-stage load-use stall
module load_use_scoreboard #(
  parameter int NUM_REGS     = 32,
  parameter int LOAD_LATENCY = 4,
  parameter int CNT_W        = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        issue_valid,
  input  logic                        issue_we,
  input  logic                        issue_is_load,
  input  logic [$clog2(NUM_REGS)-1:0] issue_waddr,
  input  logic [$clog2(NUM_REGS)-1:0] raddr1,
  input  logic [$clog2(NUM_REGS)-1:0] raddr2,
  input  logic                        rs1_used,
  input  logic                        rs2_used,
  input  logic                        pipe_stall,
  input  logic                        flush,
  output logic                        id_stall_req,
  output logic [NUM_REGS-1:0]         busy_mask,
  output logic [31:0]                 stall_cycles
);
  localparam int AW = $clog2(NUM_REGS);

  if (CNT_W < $clog2(LOAD_LATENCY + 1)) begin : g_bad_cnt_w
    $error("CNT_W cannot hold LOAD_LATENCY");
  end

  logic [NUM_REGS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic accept;

  // Stall looks only at registered counters, so it never depends on issue_* inputs
  assign id_stall_req = (rs1_used && raddr1 != '0 && cnt_q[raddr1] != '0) ||
                        (rs2_used && raddr2 != '0 && cnt_q[raddr2] != '0);
  assign accept       = issue_valid && !id_stall_req && !pipe_stall && !flush;
  assign stall_cycles = stall_cycles_q;

  // Next counter per entry: flush > new writer (load reloads, ALU clears) > decrement > hold
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = flush ? '0 :
                 (accept && issue_we && issue_waddr == AW'(r)) ? (issue_is_load ? CNT_W'(LOAD_LATENCY) : '0) :
                 (!pipe_stall && cnt_q[r] != '0) ? cnt_q[r] - CNT_W'(1) : cnt_q[r];
      busy_mask[r] = |cnt_q[r];
    end
    cnt_d[0] = '0;
    stall_cycles_d = (id_stall_req && !pipe_stall && !flush && !(&stall_cycles_q)) ?
                     stall_cycles_q + 32'd1 : stall_cycles_q;
  end

  // Counter and perf-counter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      stall_cycles_q <= '0;
    end else begin
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end
endmodule

// File: tb/tb_load_use_scoreboard.sv
// tb_load_use_scoreboard: randomized and directed scoreboard bench for load_use_scoreboard
module tb_load_use_scoreboard;
  localparam int L = 4;

  logic clk = 0;
  logic rst_n = 0;
  logic issue_valid = 0, issue_we = 0, issue_is_load = 0;
  logic [4:0] issue_waddr = 0, raddr1 = 0, raddr2 = 0;
  logic rs1_used = 0, rs2_used = 0, pipe_stall = 0, flush = 0;
  logic id_stall_req;
  logic [31:0] busy_mask;
  logic [31:0] stall_cycles;

  load_use_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_we(issue_we),
    .issue_is_load(issue_is_load), .issue_waddr(issue_waddr), .raddr1(raddr1),
    .raddr2(raddr2), .rs1_used(rs1_used), .rs2_used(rs2_used), .pipe_stall(pipe_stall),
    .flush(flush), .id_stall_req(id_stall_req), .busy_mask(busy_mask),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        stall;
    bit [31:0] mask;
    bit [31:0] sc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference: remaining un-stalled cycles each register still needs before its load data is forwardable
  int rem[32];
  bit [31:0] m_sc;

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, want);
    end
  endtask

  function automatic bit m_stall();
    return (rs1_used && raddr1 != 0 && rem[raddr1] > 0) || (rs2_used && raddr2 != 0 && rem[raddr2] > 0);
  endfunction

  task automatic drive(input bit v, input bit we, input bit ld, input int wa, input int r1, input int r2,
                       input bit u1, input bit u2, input bit ps, input bit fl, input bit rst);
    exp_t e;
    bit st, acc;
    @(negedge clk);
    issue_valid = v; issue_we = we; issue_is_load = ld; issue_waddr = 5'(wa);
    raddr1 = 5'(r1); raddr2 = 5'(r2); rs1_used = u1; rs2_used = u2;
    pipe_stall = ps; flush = fl; rst_n = !rst;
    if (rst) begin
      foreach (rem[r]) rem[r] = 0;
      m_sc = 0;
    end
    st = m_stall();
    e.stall = st;
    e.mask = 0;
    foreach (rem[r]) if (rem[r] > 0) e.mask[r] = 1'b1;
    e.sc = m_sc;
    exp_q.push_back(e);
    @(posedge clk);
    if (!rst) begin
      acc = v && !st && !ps && !fl;
      for (int r = 1; r < 32; r++) begin
        if (fl) rem[r] = 0;
        else if (acc && we && wa == r) rem[r] = ld ? L : 0;
        else if (!ps && rem[r] > 0) rem[r] = rem[r] - 1;
      end
      if (st && !ps && !fl && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
    end
  endtask

  // Monitor: every cycle the DUT presents its outputs, compare against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      cmp("id_stall_req", 32'(id_stall_req), 32'(e.stall));
      cmp("busy_mask", busy_mask, e.mask);
      cmp("stall_cycles", stall_cycles, e.sc);
    end
  end

  initial begin
    logic [31:0] s0;
    foreach (rem[r]) rem[r] = 0;
    m_sc = 0;
    // reset, then ALU write r5 and read r5
    drive(0,0,0,0,0,0,0,0,0,0,1);
    drive(1,1,0,5,0,0,0,0,0,0,0);
    drive(1,0,0,0,5,0,1,0,0,0,0);
    // load r8 then a dependent reader: four stall cycles
    drive(1,1,1,8,0,0,0,0,0,0,0);
    #1 s0 = stall_cycles;
    for (int i = 0; i < 5; i++) drive(1,0,0,0,8,0,1,0,0,0,0);
    #1 cmp("load_use_stall_count", stall_cycles - s0, 32'd4);
    cmp("r8_idle_after_stall", 32'(busy_mask[8]), 32'd0);
    // same with pipe_stall in the 2nd and 3rd cycles: six stalled cycles, four counted
    drive(1,1,1,8,0,0,0,0,0,0,0);
    #1 s0 = stall_cycles;
    for (int i = 1; i <= 7; i++) drive(1,0,0,0,8,0,1,0,(i == 2 || i == 3),0,0);
    #1 cmp("pipe_stall_count", stall_cycles - s0, 32'd4);
    cmp("r8_idle_after_pstall", 32'(busy_mask[8]), 32'd0);
    // load r8 then ALU write r8: later read does not stall
    drive(1,1,1,8,0,0,0,0,0,0,0);
    drive(1,1,0,8,1,2,1,1,0,0,0);
    drive(1,0,0,0,8,8,1,1,0,0,0);
    // r0 never tracked; load squashed by flush
    drive(1,1,1,0,0,0,0,0,0,0,0);
    drive(1,0,0,0,0,0,1,1,0,0,0);
    drive(1,1,1,3,0,0,0,0,0,1,0);
    drive(1,0,0,0,3,3,1,1,0,0,0);
    // load r9, reset mid-stall, then r9 is idle
    drive(1,1,1,9,0,0,0,0,0,0,0);
    drive(1,0,0,0,9,0,1,0,0,0,0);
    drive(1,0,0,0,9,0,1,0,0,0,1);
    drive(1,0,0,0,9,0,1,0,0,0,0);
    #1 cmp("r9_idle_after_reset", 32'(busy_mask[9]), 32'd0);
    // randomized traffic over a small register window to provoke hazards
    for (int i = 0; i < 600; i++)
      drive($urandom_range(3) != 0, $urandom_range(1), $urandom_range(1), $urandom_range(7),
            $urandom_range(7), $urandom_range(7), $urandom_range(1), $urandom_range(1),
            $urandom_range(4) == 0, $urandom_range(24) == 0, $urandom_range(99) == 0);
    @(negedge clk);
    #4;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
